// File: rtl/binary_add_pkg.sv
// Shared helpers for the pipelined add/subtract unit: chunk sizing and saturation patterns.
package binary_add_pkg;

  localparam int MAX_WIDTH = 64;

  function automatic int chunk_w(input int width, input int stages);
    return (width + stages - 1) / stages;
  endfunction

  // Patterns are built at MAX_WIDTH and narrowed to WIDTH by the caller.
  function automatic logic [MAX_WIDTH-1:0] sat_max(input int width);
    return (MAX_WIDTH'(1) << (width - 1)) - MAX_WIDTH'(1);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] sat_min(input int width);
    return MAX_WIDTH'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/binary_add_chunk.sv
// Combinational CW-bit adder slice; also reports the carry into and out of local bit MSB,
// which the top uses on the chunk holding the result's sign bit.
module binary_add_chunk
  import binary_add_pkg::*;
#(
  parameter int CW  = 4,
  parameter int MSB = CW - 1
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout,
  output logic          c_msb,
  output logic          c_top
);

  logic [CW:0] full;

  assign full  = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
  assign sum   = full[CW-1:0];
  assign cout  = full[CW];
  assign c_msb = a[MSB] ^ b[MSB] ^ full[MSB];
  assign c_top = (a[MSB] & b[MSB]) | (c_msb & (a[MSB] ^ b[MSB]));

endmodule

// File: rtl/binary_add_pipe.sv
// Pipelined add/subtract: the carry chain is cut into STAGES chunks, operands and partial sums
// travel together through the stage registers, and the last stage doubles as the output register.
module binary_add_pipe
  import binary_add_pkg::*;
#(
  parameter int WIDTH  = 11,
  parameter int STAGES = 2,
  parameter int SAT    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf
);

  localparam int CW      = chunk_w(WIDTH, STAGES);
  localparam int PW      = CW * STAGES;
  localparam int K_TOP   = (WIDTH - 1) / CW;
  localparam int MSB_LOC = (WIDTH - 1) % CW;
  localparam int LAST    = STAGES - 1;
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));

  // Index s holds what stage s sees on its inputs (_st) and what it produces (_nx).
  logic [PW-1:0] a_st   [STAGES];
  logic [PW-1:0] b_st   [STAGES];
  logic [PW-1:0] sum_st [STAGES];
  logic [PW-1:0] sum_nx [STAGES];
  logic [CW-1:0] csum   [STAGES];
  logic          c_st   [STAGES];
  logic          v_st   [STAGES];
  logic          ovf_st [STAGES];
  logic          co_st  [STAGES];
  logic          c_nx   [STAGES];
  logic          c_msb  [STAGES];
  logic          c_top  [STAGES];
  logic          ovf_nx [STAGES];
  logic          co_nx  [STAGES];
  logic [WIDTH-1:0] b_eff;

  // Operands are zero-padded above WIDTH so the truncated top chunk adds harmless zeros.
  assign b_eff     = sub ? ~B : B;
  assign a_st[0]   = PW'(A);
  assign b_st[0]   = PW'(b_eff);
  assign sum_st[0] = '0;
  assign c_st[0]   = sub;
  assign v_st[0]   = in_valid;
  assign ovf_st[0] = 1'b0;
  assign co_st[0]  = 1'b0;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    binary_add_chunk #(
      .CW  (CW),
      .MSB (MSB_LOC)
    ) u_chunk (
      .a     (a_st[s][s*CW +: CW]),
      .b     (b_st[s][s*CW +: CW]),
      .cin   (c_st[s]),
      .sum   (csum[s]),
      .cout  (c_nx[s]),
      .c_msb (c_msb[s]),
      .c_top (c_top[s])
    );

    assign sum_nx[s] = sum_st[s] | (PW'(csum[s]) << (s * CW));
    // Flags are captured in the chunk that owns bit WIDTH-1 and then just ride along.
    assign ovf_nx[s] = (s == K_TOP) ? (c_msb[s] ^ c_top[s]) : ovf_st[s];
    assign co_nx[s]  = (s == K_TOP) ? c_top[s] : co_st[s];

    if (s < LAST) begin : g_reg
      logic [PW-1:0] a_q;
      logic [PW-1:0] b_q;
      logic [PW-1:0] sum_q;
      logic          c_q;
      logic          v_q;
      logic          ovf_q;
      logic          co_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= 1'b0;
        end else if (en) begin
          a_q   <= a_st[s];
          b_q   <= b_st[s];
          sum_q <= sum_nx[s];
          c_q   <= c_nx[s];
          v_q   <= v_st[s];
          ovf_q <= ovf_nx[s];
          co_q  <= co_nx[s];
        end
      end

      assign a_st[s+1]   = a_q;
      assign b_st[s+1]   = b_q;
      assign sum_st[s+1] = sum_q;
      assign c_st[s+1]   = c_q;
      assign v_st[s+1]   = v_q;
      assign ovf_st[s+1] = ovf_q;
      assign co_st[s+1]  = co_q;
    end
  end

  // Result registers load only for a valid result so bubbles leave the last answer visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      S         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (en) begin
      out_valid <= v_st[LAST];
      if (v_st[LAST]) begin
        cout <= co_nx[LAST];
        ovf  <= ovf_nx[LAST];
        if (SAT != 0 && ovf_nx[LAST]) begin
          S <= a_st[LAST][WIDTH-1] ? SAT_MIN : SAT_MAX;
        end else begin
          S <= sum_nx[LAST][WIDTH-1:0];
        end
      end
    end
  end

endmodule
